// File: rtl/disp_mode_ctrl_pkg.sv
// Shared definitions for the display mode controller.
//   t_sync        : one video timing set (porches, sync widths, active size)
//   t_mode_state  : mode-change FSM states
//   NUM_MODES     : number of selectable modes
//   MODE_TABLE    : timing for each mode index
//   mode_timing() : table lookup by 2-bit mode index
package pkg_disp;

  localparam int NUM_MODES = 4;

  typedef struct packed {
    logic [11:0] horz_fp;
    logic [11:0] horz_sync;
    logic [11:0] horz_bp;
    logic [11:0] horz_pix;
    logic [11:0] vert_fp;
    logic [11:0] vert_sync;
    logic [11:0] vert_bp;
    logic [11:0] vert_pix;
  } t_sync;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_FS = 3'd1,
    MUTE    = 3'd2,
    APPLY   = 3'd3,
    SETTLE  = 3'd4
  } t_mode_state;

  localparam t_sync MODE_TABLE [NUM_MODES] = '{
    '{12'd24,  12'd136, 12'd160, 12'd1024, 12'd10, 12'd8, 12'd30, 12'd600},  // 1024x600
    '{12'd16,  12'd96,  12'd48,  12'd640,  12'd10, 12'd2, 12'd33, 12'd480},  // 640x480
    '{12'd40,  12'd128, 12'd88,  12'd800,  12'd1,  12'd4, 12'd23, 12'd600},  // 800x600
    '{12'd110, 12'd40,  12'd220, 12'd1280, 12'd5,  12'd5, 12'd20, 12'd720}   // 1280x720
  };

  function automatic t_sync mode_timing(input logic [1:0] idx);
    return MODE_TABLE[idx];
  endfunction

endpackage

// File: rtl/disp_mode_ctrl_wdog.sv
// disp_wdog: frame_start watchdog for the display mode controller.
// Compiled only when DISP_WDOG_EN is defined.
//   clk     in  pixel clock
//   rst_n   in  asynchronous active-low reset
//   restart in  clear the timeout counter
//   timeout out one-cycle pulse after CYCLES cycles without restart
`ifdef DISP_WDOG_EN
module disp_wdog #(
  parameter int unsigned CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic timeout
);

  localparam int unsigned LIMIT = CYCLES - 32'd1;

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign timeout = (cnt_q == LIMIT);

  // Counter restarts on request or after firing, so each silent period yields one pulse.
  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (restart || timeout) begin
      cnt_d = 32'd0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/disp_mode_ctrl.sv
// disp_mode_ctrl: glitch-free display mode switch. A request for a new mode
// mutes the picture, waits MUTE_FRAMES frames, loads the new timing while the
// timing generator is stopped for one cycle, waits SETTLE_FRAMES frames and
// then unmutes and acknowledges.
// Optional feature: DISP_WDOG_EN adds a frame_start watchdog (disp_wdog) that
// stands in for a missing frame_start after WDOG_CYCLES cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mode_sel, mode_req    requested mode and request level (held until ack)
//   mode_ack              one-cycle completion pulse
//   frame_start           one-cycle pulse at first blanking line
//   sp, sync_en           active timing set and timing generator enable
//   mute, busy            picture blanking and change-in-progress flags
//   cur_mode, frame_cnt   active mode and free-running frame counter
module disp_mode_ctrl
  import pkg_disp::*;
#(
  parameter int unsigned MUTE_FRAMES   = 2,
  parameter int unsigned SETTLE_FRAMES = 1,
  parameter int unsigned WDOG_CYCLES   = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode_sel,
  input  logic        mode_req,
  output logic        mode_ack,
  input  logic        frame_start,
  output t_sync       sp,
  output logic        sync_en,
  output logic        mute,
  output logic        busy,
  output logic [1:0]  cur_mode,
  output logic [15:0] frame_cnt
);

  if (MUTE_FRAMES < 1 || MUTE_FRAMES > 15 || SETTLE_FRAMES < 1 ||
      SETTLE_FRAMES > 15 || WDOG_CYCLES < 2) begin : g_param_check
    $error("disp_mode_ctrl: parameter out of range");
  end

  localparam logic [3:0] MUTE_N   = 4'(MUTE_FRAMES);
  localparam logic [3:0] SETTLE_N = 4'(SETTLE_FRAMES);

  t_mode_state state_q, state_d;
  logic [1:0]  pending_q, pending_d;
  logic [3:0]  fcount_q, fcount_d;
  t_sync       sp_q, sp_d;
  logic        sync_en_q, sync_en_d;
  logic        mute_q, mute_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic [1:0]  cur_mode_q, cur_mode_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        fs_eff;

`ifdef DISP_WDOG_EN
  logic wdog_window;
  logic wdog_restart;
  logic wdog_timeout;

  // Watchdog only matters while waiting on frames; elsewhere it is held cleared.
  assign wdog_window  = (state_q == WAIT_FS) || (state_q == MUTE) || (state_q == SETTLE);
  assign wdog_restart = frame_start || (state_d != state_q) || !wdog_window;
  assign fs_eff       = frame_start || (wdog_timeout && wdog_window);

  disp_wdog #(
    .CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (wdog_restart),
    .timeout (wdog_timeout)
  );
`else
  assign fs_eff = frame_start;
`endif

  // Next-state and output logic of the mode-change FSM.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    fcount_d    = fcount_q;
    sp_d        = sp_q;
    sync_en_d   = sync_en_q;
    mute_d      = mute_q;
    busy_d      = busy_q;
    ack_d       = 1'b0;
    cur_mode_d  = cur_mode_q;
    frame_cnt_d = fs_eff ? (frame_cnt_q + 16'd1) : frame_cnt_q;
    case (state_q)
      IDLE: begin
        // Requester still holds mode_req during the ack cycle; don't re-serve it.
        if (mode_req && !ack_q) begin
          if (mode_sel == cur_mode_q) begin
            ack_d = 1'b1;
          end else begin
            pending_d = mode_sel;
            busy_d    = 1'b1;
            fcount_d  = 4'd0;
            state_d   = WAIT_FS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_FS: begin
        if (fs_eff) begin
          mute_d   = 1'b1;
          fcount_d = 4'd1;
          state_d  = MUTE;
        end else begin
          state_d = WAIT_FS;
        end
      end
      MUTE: begin
        // The pulse that entered MUTE already counts as frame one.
        if ((fcount_q >= MUTE_N) || (fs_eff && ((fcount_q + 4'd1) >= MUTE_N))) begin
          sync_en_d   = 1'b0;
          sp_d        = mode_timing(pending_q);
          cur_mode_d  = pending_q;
          frame_cnt_d = 16'd0;
          fcount_d    = 4'd0;
          state_d     = APPLY;
        end else if (fs_eff) begin
          fcount_d = fcount_q + 4'd1;
        end else begin
          fcount_d = fcount_q;
        end
      end
      APPLY: begin
        sync_en_d   = 1'b1;
        frame_cnt_d = frame_cnt_q;
        state_d     = SETTLE;
      end
      SETTLE: begin
        if (fs_eff && ((fcount_q + 4'd1) >= SETTLE_N)) begin
          mute_d   = 1'b0;
          busy_d   = 1'b0;
          ack_d    = 1'b1;
          fcount_d = 4'd0;
          state_d  = IDLE;
        end else if (fs_eff) begin
          fcount_d = fcount_q + 4'd1;
        end else begin
          fcount_d = fcount_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset returns to mode 0 and drops any pending change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= 2'd0;
      fcount_q    <= 4'd0;
      sp_q        <= MODE_TABLE[0];
      sync_en_q   <= 1'b1;
      mute_q      <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      cur_mode_q  <= 2'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      fcount_q    <= fcount_d;
      sp_q        <= sp_d;
      sync_en_q   <= sync_en_d;
      mute_q      <= mute_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      cur_mode_q  <= cur_mode_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sp        = sp_q;
  assign sync_en   = sync_en_q;
  assign mute      = mute_q;
  assign busy      = busy_q;
  assign mode_ack  = ack_q;
  assign cur_mode  = cur_mode_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Self-checking bench for disp_mode_ctrl: directed scenarios followed by
// random requests and frame pulses, all compared against a transaction-level
// reference model of the mode change sequence.
module tb_disp_mode_ctrl;
  import pkg_disp::*;

`ifdef DISP_WDOG_EN
  localparam int unsigned WDOG = 100;
`else
  localparam int unsigned WDOG = 2_000_000;
`endif
  localparam int MUTE_F   = 2;
  localparam int SETTLE_F = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode_sel;
  logic        mode_req;
  logic        mode_ack;
  logic        frame_start;
  t_sync       sp;
  logic        sync_en;
  logic        mute;
  logic        busy;
  logic [1:0]  cur_mode;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  disp_mode_ctrl #(
    .MUTE_FRAMES   (MUTE_F),
    .SETTLE_FRAMES (SETTLE_F),
    .WDOG_CYCLES   (WDOG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_sel    (mode_sel),
    .mode_req    (mode_req),
    .mode_ack    (mode_ack),
    .frame_start (frame_start),
    .sp          (sp),
    .sync_en     (sync_en),
    .mute        (mute),
    .busy        (busy),
    .cur_mode    (cur_mode),
    .frame_cnt   (frame_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference timing table, written out independently of the package.
  function automatic t_sync ref_mode(input logic [1:0] m);
    t_sync s;
    case (m)
      2'd0:    s = '{12'd24,  12'd136, 12'd160, 12'd1024, 12'd10, 12'd8, 12'd30, 12'd600};
      2'd1:    s = '{12'd16,  12'd96,  12'd48,  12'd640,  12'd10, 12'd2, 12'd33, 12'd480};
      2'd2:    s = '{12'd40,  12'd128, 12'd88,  12'd800,  12'd1,  12'd4, 12'd23, 12'd600};
      default: s = '{12'd110, 12'd40,  12'd220, 12'd1280, 12'd5,  12'd5, 12'd20, 12'd720};
    endcase
    return s;
  endfunction

  // Reference model: a change is tracked as "frames seen before apply",
  // an apply cycle, and "frames seen after apply".
  logic        m_busy, m_applying, m_after, m_mute, m_sync_en, m_ack;
  logic [1:0]  m_pending, m_cur;
  logic [15:0] m_cnt;
  t_sync       m_sp;
  int          m_pre_n, m_post_n;

  task automatic model_reset();
    m_busy = 1'b0; m_applying = 1'b0; m_after = 1'b0;
    m_mute = 1'b0; m_sync_en = 1'b1; m_ack = 1'b0;
    m_pending = 2'd0; m_cur = 2'd0; m_cnt = 16'd0;
    m_sp = ref_mode(2'd0); m_pre_n = 0; m_post_n = 0;
  endtask

  task automatic model_step();
    logic ack_next;
    ack_next = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (m_applying) begin
      m_applying = 1'b0;
      m_sync_en  = 1'b1;
      m_after    = 1'b1;
      m_post_n   = 0;
    end else begin
      if (frame_start) m_cnt = m_cnt + 16'd1;
      if (!m_busy) begin
        if (mode_req && !m_ack) begin
          if (mode_sel == m_cur) ack_next = 1'b1;
          else begin
            m_busy = 1'b1; m_pending = mode_sel; m_pre_n = 0; m_after = 1'b0;
          end
        end
      end else if (!m_after) begin
        if (frame_start) begin
          m_pre_n++;
          m_mute = 1'b1;
          if (m_pre_n >= MUTE_F) begin
            m_applying = 1'b1; m_sync_en = 1'b0;
            m_sp = ref_mode(m_pending); m_cur = m_pending; m_cnt = 16'd0;
          end
        end
      end else if (frame_start) begin
        m_post_n++;
        if (m_post_n >= SETTLE_F) begin
          m_busy = 1'b0; m_mute = 1'b0; m_after = 1'b0; ack_next = 1'b1;
        end
      end
      m_ack = ack_next;
    end
  endtask

  task automatic check_all();
    check_val("mode_ack",  96'(mode_ack),  96'(m_ack));
    check_val("busy",      96'(busy),      96'(m_busy));
    check_val("mute",      96'(mute),      96'(m_mute));
    check_val("sync_en",   96'(sync_en),   96'(m_sync_en));
    check_val("cur_mode",  96'(cur_mode),  96'(m_cur));
    check_val("frame_cnt", 96'(frame_cnt), 96'(m_cnt));
    check_val("sp",        96'(sp),        96'(m_sp));
  endtask

  int          sync_low;
  logic [11:0] apply_hpix;

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    if (sync_en === 1'b0) begin
      sync_low++;
      apply_hpix = sp.horz_pix;
    end
    if (m_ack) mode_req = 1'b0;
  endtask

  task automatic pulse_fs(input int gap);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    rst_n = 1'b0; mode_sel = 2'd0; mode_req = 1'b0; frame_start = 1'b0;
    sync_low = 0; apply_hpix = 12'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    tick();

    // Same-mode request: immediate ack, no change.
    mode_sel = 2'd0; mode_req = 1'b1;
    tick();
    check_val("same_ack", 96'(mode_ack), 96'(1'b1));
    repeat (3) tick();

    // Change to mode 3 with sparse frame pulses.
    mode_sel = 2'd3; mode_req = 1'b1;
    sync_low = 0;
    repeat (2) tick();
    pulse_fs(4);
    pulse_fs(4);
    pulse_fs(4);
    check_val("apply_len", 96'(sync_low), 96'(1));
    check_val("apply_hpix", 96'(apply_hpix), 96'(12'd1280));
    check_val("m3_cur", 96'(cur_mode), 96'(2'd3));

    // Change to mode 1, coincident frame pulse ignored, mode_sel changed while busy.
    mode_sel = 2'd1; mode_req = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    mode_sel = 2'd2;
    repeat (2) tick();
    pulse_fs(3);
    pulse_fs(3);
    pulse_fs(3);
    check_val("busy_sel_cur", 96'(cur_mode), 96'(2'd1));

    // Reset in the middle of a change.
    mode_sel = 2'd2; mode_req = 1'b1;
    tick();
    pulse_fs(2);
    @(negedge clk);
    rst_n = 1'b0; mode_req = 1'b0;
    #1;
    check_val("rst_mute", 96'(mute), 96'(1'b0));
    check_val("rst_cur", 96'(cur_mode), 96'(2'd0));
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    mode_sel = 2'd2; mode_req = 1'b1;
    tick();
    pulse_fs(2);
    pulse_fs(2);
    pulse_fs(2);
    check_val("post_rst_cur", 96'(cur_mode), 96'(2'd2));

    // Random requests and frame pulses.
    for (int i = 0; i < 4000; i++) begin
      frame_start = ($urandom_range(0, 7) == 0);
      if (!mode_req && ($urandom_range(0, 11) == 0)) begin
        mode_req = 1'b1;
        mode_sel = 2'($urandom_range(0, 3));
      end else if (m_busy && ($urandom_range(0, 3) == 0)) begin
        mode_sel = 2'($urandom_range(0, 3));
      end
      tick();
    end
    frame_start = 1'b0;
    repeat (30) pulse_fs(1);

    // Frame counter wrap with continuous frame pulses while idle.
    mode_req = 1'b0; frame_start = 1'b1;
    repeat (65540) tick();
    frame_start = 1'b0;
    tick();

`ifdef DISP_WDOG_EN
    // Watchdog: no frame pulses at all, change must still complete.
    begin
      int n;
      mode_sel = m_cur + 2'd1; mode_req = 1'b1;
      n = 0;
      while (mute !== 1'b1 && n < 400) begin
        @(negedge clk);
        n++;
      end
      check_val("wdog_mute_lat", 96'(n >= 95 && n <= 110), 96'(1'b1));
      while (mode_ack !== 1'b1 && n < 800) begin
        @(negedge clk);
        n++;
      end
      check_val("wdog_done_lat", 96'(n >= 250 && n <= 450), 96'(1'b1));
      mode_req = 1'b0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
